// File: rtl/dense_layer_mac.sv
// Fixed-point fully-connected layer: out[j] = act(sum_i W[j][i]*x[i] + b[j]), weights and bias fetched from shared RAM.
// Latency: N_IN+2 cycles per neuron with zero-wait memory; start to done = N_OUT*(N_IN+2)+1 cycles.
// Backpressure: mem_read is held with a stable address until mem_resp; each wait-state cycle stalls exactly one cycle.
module dense_layer_mac #(
  parameter int N_IN  = 100,
  parameter int N_OUT = 100,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  parameter int AW    = 24,
  localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_wr_en,
  input  logic [IW-1:0] in_wr_addr,
  input  logic [DW-1:0] in_wr_data,
  input  logic          start,
  input  logic [7:0]    layer_num,
  input  logic          relu_en,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_resp,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [OW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  // i must be able to reach N_IN, where the bias word is fetched
  localparam int CW = $clog2(N_IN + 1);
  localparam logic [AW-1:0] ROW_STRIDE   = AW'(N_IN + 1);
  localparam logic [AW-1:0] LAYER_STRIDE = AW'(N_OUT * (N_IN + 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_i;
  logic [OW-1:0]             r_j;
  logic [AW-1:0]             r_row;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_relu;
  logic [DW-1:0]             r_xbuf [N_IN];

  logic                      w_start_ok;
  logic                      w_busy_state;
  logic                      w_last_word;
  logic                      w_last_neuron;
  logic signed [DW-1:0]      w_x;
  logic signed [2*DW-1:0]    w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic signed [ACC_W-1:0]   w_shift;
  logic [DW-1:0]             w_sat;
  logic [DW-1:0]             w_act;

  // start is only honoured when no computation is running (IDLE or the DONE cycle)
  assign w_busy_state  = (r_state == S_FETCH) || (r_state == S_EMIT);
  assign w_start_ok    = start && !w_busy_state;
  assign w_last_word   = (r_i == CW'(N_IN));
  assign w_last_neuron = (r_j == OW'(N_OUT - 1));

  // x[i] is only meaningful for weight words; the bias slot reads as zero
  assign w_x        = w_last_word ? '0 : r_xbuf[r_i[IW-1:0]];
  assign w_prod     = $signed({{DW{mem_rdata[DW-1]}}, mem_rdata}) * $signed({{DW{w_x[DW-1]}}, w_x});
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  // bias is Q.FRAC, products are Q.2FRAC: align bias before adding
  assign w_bias_ext = {{(ACC_W-DW){mem_rdata[DW-1]}}, mem_rdata} <<< FRAC;
  assign w_shift    = r_acc >>> FRAC;

  // address and result outputs read zero outside the states that own them
  assign mem_addr = mem_read  ? (r_row + AW'(r_i)) : '0;
  assign out_idx  = out_valid ? r_j   : '0;
  assign out_data = out_valid ? w_act : '0;

  // floor-shift result, saturate to DW bits, then optional ReLU
  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shift < SAT_MIN) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
    end
    w_act = (r_relu && w_sat[DW-1]) ? '0 : w_sat;
  end

  // state register; reset aborts immediately so mem_read drops asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and control outputs
  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        if (mem_resp && w_last_word) w_next = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        w_next    = w_last_neuron ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_FETCH : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: layer setup on accepted start, accumulate on consumed words, advance neuron on emit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i    <= '0;
      r_j    <= '0;
      r_row  <= '0;
      r_acc  <= '0;
      r_relu <= 1'b0;
    end else if (w_start_ok) begin
      r_i    <= '0;
      r_j    <= '0;
      r_acc  <= '0;
      r_relu <= relu_en;
      r_row  <= AW'(layer_num) * LAYER_STRIDE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_resp) begin
            if (w_last_word) begin
              r_acc <= r_acc + w_bias_ext;
            end else begin
              r_acc <= r_acc + w_prod_ext;
              r_i   <= r_i + 1'b1;
            end
          end
        end
        S_EMIT: begin
          r_acc <= '0;
          r_i   <= '0;
          if (!w_last_neuron) begin
            r_j   <= r_j + 1'b1;
            r_row <= r_row + ROW_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // input vector buffer, writable only while not computing; out-of-range indices dropped
  always_ff @(posedge clk) begin
    if (in_wr_en && !w_busy_state && ({1'b0, in_wr_addr} < (IW+1)'(N_IN))) begin
      r_xbuf[in_wr_addr] <= in_wr_data;
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
module tb_dense_layer_mac;

  localparam int N_IN = 3, N_OUT = 2, DW = 16, FRAC = 8, ACC_W = 40, AW = 24;

  logic          clk;
  logic          reset;
  logic          in_wr_en;
  logic [1:0]    in_wr_addr;
  logic [15:0]   in_wr_data;
  logic          start;
  logic [7:0]    layer_num;
  logic          relu_en;
  logic          mem_read;
  logic [23:0]   mem_addr;
  logic          mem_resp;
  logic [15:0]   mem_rdata;
  logic          out_valid;
  logic [0:0]    out_idx;
  logic [15:0]   out_data;
  logic          busy;
  logic          done;

  dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .start(start), .layer_num(layer_num), .relu_en(relu_en),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x0, x1, x2;
    int          layer;
    bit          relu;
    int          maxw;
    logic [15:0] e0, e1;
  } vec_t;

  typedef struct {
    logic [0:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          max_wait = 0;
  int          waits    = 0;
  logic [15:0] mem [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_exp(input logic [15:0] e0, input logic [15:0] e1);
    exp_t e;
    e.idx = 1'b0; e.data = e0; sb.push_back(e);
    e.idx = 1'b1; e.data = e1; sb.push_back(e);
  endtask

  // weight memory model with random wait states; also checks address stability while pending
  initial begin : responder
    bit          req_act = 1'b0;
    int          wleft = 0;
    logic [23:0] held = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read) begin
        if (req_act) chk("addr_stable", mem_addr, held);
        else begin
          req_act = 1'b1;
          held    = mem_addr;
          wleft   = int'($urandom_range(max_wait, 0));
        end
        if (wleft == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem[mem_addr[5:0]];
          req_act   = 1'b0;
        end else begin
          mem_resp  = 1'b0;
          mem_rdata = 16'($urandom);
          wleft--;
          waits++;
        end
      end else begin
        req_act   = 1'b0;
        mem_resp  = 1'($urandom);
        mem_rdata = 16'($urandom);
      end
    end
  end

  // scoreboard: every out_valid strobe must match the oldest expected result
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // load x0,x1 then write x2 in the same cycle as start
  task automatic load_and_start(input vec_t v);
    @(negedge clk); in_wr_en = 1'b1; in_wr_addr = 2'd0; in_wr_data = v.x0;
    @(negedge clk); in_wr_addr = 2'd1; in_wr_data = v.x1;
    @(negedge clk); in_wr_addr = 2'd2; in_wr_data = v.x2;
    start = 1'b1; layer_num = 8'(v.layer); relu_en = v.relu;
    max_wait = v.maxw; waits = 0;
    push_exp(v.e0, v.e1);
  endtask

  task automatic run(input vec_t v, input bit pulse_busy);
    int cyc = 0;
    bit got = 1'b0;
    load_and_start(v);
    while (cyc < 500 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; in_wr_en = 1'b0;
        chk("first_addr", 32'(mem_addr), 32'(v.layer * 8));
      end
      if (pulse_busy && cyc == 3) begin
        start = 1'b1; layer_num = 8'd1;
        in_wr_en = 1'b1; in_wr_addr = 2'd0; in_wr_data = 16'h7FFF;
      end
      if (pulse_busy && cyc == 4) begin
        start = 1'b0; in_wr_en = 1'b0;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(11 + waits));
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin : main
    vec_t tbl [9];
    vec_t v;
    int   cyc;
    bit   got;

    tbl[0] = '{16'd256,  16'd512,  16'hFF00, 0, 1'b0, 0, 16'd320,  16'hFF00};
    tbl[1] = '{16'd256,  16'd512,  16'hFF00, 0, 1'b1, 0, 16'd320,  16'h0000};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 1'b0, 0, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 2, 1'b0, 3, 16'h8000, 16'h7FFF};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 2, 1'b1, 5, 16'h0000, 16'h7FFF};
    tbl[5] = '{16'd256,  16'd512,  16'hFF00, 3, 1'b0, 5, 16'd512,  16'hFD00};
    tbl[6] = '{16'd256,  16'd512,  16'hFF00, 3, 1'b1, 2, 16'd512,  16'h0000};
    tbl[7] = '{16'd1,    16'd0,    16'd0,    3, 1'b0, 4, 16'd1,    16'hFF80};
    tbl[8] = '{16'd256,  16'd512,  16'hFF00, 0, 1'b0, 5, 16'd320,  16'hFF00};

    for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
    mem[0]  = 16'd256;  mem[1]  = 16'd128;  mem[2]  = 16'd256;  mem[3]  = 16'd64;
    mem[4]  = 16'hFF00; mem[5]  = 16'd0;    mem[6]  = 16'd0;    mem[7]  = 16'd0;
    for (int a = 8; a < 16; a++) mem[a] = 16'h7FFF;
    for (int a = 16; a < 20; a++) mem[a] = 16'h8000;
    for (int a = 20; a < 24; a++) mem[a] = 16'h7FFF;
    mem[24] = 16'd256;  mem[25] = 16'd256;  mem[26] = 16'd256;  mem[27] = 16'd0;
    mem[28] = 16'd128;  mem[29] = 16'hFF80; mem[30] = 16'd512;  mem[31] = 16'hFF80;

    reset = 1'b1; in_wr_en = 1'b0; in_wr_addr = '0; in_wr_data = '0;
    start = 1'b0; layer_num = '0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read",  32'(mem_read),  32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) run(tbl[k], k == 3);

    // reset asserted in the middle of FETCH: everything drops at once, next run is clean
    load_and_start(tbl[0]);
    max_wait = 2;
    repeat (3) @(negedge clk);
    start = 1'b0; in_wr_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_read",  32'(mem_read),  32'd0);
    chk("abort_mem_addr",  32'(mem_addr),  32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_done",      32'(done),      32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(tbl[5], 1'b0);

    // start held through DONE: second layer begins with no idle gap; layer/relu sampled per start
    v = tbl[0];
    v.maxw = 2;
    load_and_start(v);
    cyc = 0; got = 1'b0;
    while (cyc < 500 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        in_wr_en = 1'b0; layer_num = 8'd3; relu_en = 1'b1;
      end
      if (done) got = 1'b1;
    end
    chk("b2b_first_done", 32'(got), 32'd1);
    chk("b2b_first_cycle", 32'(cyc), 32'(11 + waits));
    chk("b2b_busy_in_done", 32'(busy), 32'd0);
    push_exp(16'd512, 16'h0000);
    waits = 0;
    cyc = 0; got = 1'b0;
    while (cyc < 500 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("b2b_busy_resumed", 32'(busy), 32'd1);
        chk("b2b_first_addr", 32'(mem_addr), 32'd24);
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    chk("b2b_second_done", 32'(got), 32'd1);
    chk("b2b_second_cycle", 32'(cyc), 32'(11 + waits));

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
